// File: rtl/bcd_time_counter_if.sv
// Bundle of the mm:ss counter's control inputs, BCD digit outputs and carry pulses.
// Optional macro BCD_TIME_COUNTER_DOWN_EN adds the 'down' direction control.
interface bcd_time_counter_if #(
  parameter int DW = 4
);
  logic          tick_in;
  logic          enable;
  logic          clear;
`ifdef BCD_TIME_COUNTER_DOWN_EN
  logic          down;
`endif
  logic [DW-1:0] sec_ones;
  logic [DW-1:0] sec_tens;
  logic [DW-1:0] min_ones;
  logic [DW-1:0] min_tens;
  logic          sec_carry;
  logic          min_carry;

`ifdef BCD_TIME_COUNTER_DOWN_EN
  modport master (
    output tick_in, enable, clear, down,
    input  sec_ones, sec_tens, min_ones, min_tens, sec_carry, min_carry
  );
  modport slave (
    input  tick_in, enable, clear, down,
    output sec_ones, sec_tens, min_ones, min_tens, sec_carry, min_carry
  );
`else
  modport master (
    output tick_in, enable, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, sec_carry, min_carry
  );
  modport slave (
    input  tick_in, enable, clear,
    output sec_ones, sec_tens, min_ones, min_tens, sec_carry, min_carry
  );
`endif
endinterface

// File: rtl/bcd_time_counter.sv
// Two-stage BCD mm:ss counter stepped by rising edges of a clk-synchronous tick level.
// Optional macro BCD_TIME_COUNTER_DOWN_EN enables counting down when bus.down=1.
module bcd_time_counter #(
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int DW      = 4
) (
  input logic                clk,
  input logic                rst,
  bcd_time_counter_if.slave  bus
);

  // Last legal value of each stage, split into BCD digits.
  localparam logic [DW-1:0] SEC_LAST_TENS = DW'((SEC_MOD - 1) / 10);
  localparam logic [DW-1:0] SEC_LAST_ONES = DW'((SEC_MOD - 1) % 10);
  localparam logic [DW-1:0] MIN_LAST_TENS = DW'((MIN_MOD - 1) / 10);
  localparam logic [DW-1:0] MIN_LAST_ONES = DW'((MIN_MOD - 1) % 10);
  localparam logic [DW-1:0] NINE          = DW'(9);
  localparam logic [DW-1:0] ZERO          = '0;

  logic          tick_q;
  logic [DW-1:0] sec_ones_q, sec_ones_d;
  logic [DW-1:0] sec_tens_q, sec_tens_d;
  logic [DW-1:0] min_ones_q, min_ones_d;
  logic [DW-1:0] min_tens_q, min_tens_d;
  logic          sec_carry_q, sec_carry_d;
  logic          min_carry_q, min_carry_d;
  logic          step;
  logic [2*DW:0] sec_res;
  logic [2*DW:0] min_res;

  // Result layout: {wrapped, tens, ones}.
  function automatic logic [2*DW:0] pair_inc(
    input logic [DW-1:0] tens,
    input logic [DW-1:0] ones,
    input logic [DW-1:0] last_tens,
    input logic [DW-1:0] last_ones
  );
    if (tens == last_tens && ones == last_ones) begin
      return {1'b1, ZERO, ZERO};
    end else if (ones == NINE) begin
      return {1'b0, tens + DW'(1), ZERO};
    end else begin
      return {1'b0, tens, ones + DW'(1)};
    end
  endfunction

`ifdef BCD_TIME_COUNTER_DOWN_EN
  function automatic logic [2*DW:0] pair_dec(
    input logic [DW-1:0] tens,
    input logic [DW-1:0] ones,
    input logic [DW-1:0] last_tens,
    input logic [DW-1:0] last_ones
  );
    if (tens == ZERO && ones == ZERO) begin
      return {1'b1, last_tens, last_ones};
    end else if (ones == ZERO) begin
      return {1'b0, tens - DW'(1), NINE};
    end else begin
      return {1'b0, tens, ones - DW'(1)};
    end
  endfunction
`endif

  assign step = bus.tick_in & ~tick_q & bus.enable;

  always_comb begin
`ifdef BCD_TIME_COUNTER_DOWN_EN
    if (bus.down) begin
      sec_res = pair_dec(sec_tens_q, sec_ones_q, SEC_LAST_TENS, SEC_LAST_ONES);
      min_res = pair_dec(min_tens_q, min_ones_q, MIN_LAST_TENS, MIN_LAST_ONES);
    end else begin
      sec_res = pair_inc(sec_tens_q, sec_ones_q, SEC_LAST_TENS, SEC_LAST_ONES);
      min_res = pair_inc(min_tens_q, min_ones_q, MIN_LAST_TENS, MIN_LAST_ONES);
    end
`else
    sec_res = pair_inc(sec_tens_q, sec_ones_q, SEC_LAST_TENS, SEC_LAST_ONES);
    min_res = pair_inc(min_tens_q, min_ones_q, MIN_LAST_TENS, MIN_LAST_ONES);
`endif
  end

  // Clear beats step; minutes only move on the cycle the seconds wrap.
  always_comb begin
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    sec_carry_d = 1'b0;
    min_carry_d = 1'b0;
    if (bus.clear) begin
      sec_ones_d = ZERO;
      sec_tens_d = ZERO;
      min_ones_d = ZERO;
      min_tens_d = ZERO;
    end else if (step) begin
      {sec_tens_d, sec_ones_d} = sec_res[2*DW-1:0];
      sec_carry_d              = sec_res[2*DW];
      if (sec_res[2*DW]) begin
        {min_tens_d, min_ones_d} = min_res[2*DW-1:0];
        min_carry_d              = min_res[2*DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q      <= 1'b0;
      sec_ones_q  <= ZERO;
      sec_tens_q  <= ZERO;
      min_ones_q  <= ZERO;
      min_tens_q  <= ZERO;
      sec_carry_q <= 1'b0;
      min_carry_q <= 1'b0;
    end else begin
      tick_q      <= bus.tick_in;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      sec_carry_q <= sec_carry_d;
      min_carry_q <= min_carry_d;
    end
  end

  assign bus.sec_ones  = sec_ones_q;
  assign bus.sec_tens  = sec_tens_q;
  assign bus.min_ones  = min_ones_q;
  assign bus.min_tens  = min_tens_q;
  assign bus.sec_carry = sec_carry_q;
  assign bus.min_carry = min_carry_q;

endmodule
